pipeline_hazard_ctrl: RTL

- Central stall/flush/forward controller for the 5-stage RISC-V pipeline.
- Drives the en/clear pins of every segment register (IF, ID, EX, MEM, WB). Each en is the inverse of its Stall; each clear is its Flush.
- Resolves load-use, branch/jump and data-cache-miss hazards, and generates EX-stage forwarding selects.
- Contains a miss-wait FSM with a watchdog counter so the pipeline freezes cleanly across multi-cycle memory accesses.

---
 rtl/pipeline_hazard_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl
// ----------------------------------------------------------------------------
// Central stall / flush / forward controller for the 5-stage RISC-V pipeline.
// Drives the enable (inverse of Stall*) and clear (Flush*) pins of the IF, ID,
// EX, MEM and WB segment registers.  Resolves load-use, branch/jump and
// data-cache-miss hazards and produces the EX-stage forwarding selects.
// A small miss-wait FSM freezes the pipeline across multi-cycle memory
// accesses, guarded by a watchdog counter that raises a sticky miss_err.
//
// Parameters:
//   MISS_TIMEOUT  cycles in MISS_WAIT before miss_err sets (1..65535)
//   TO_W          width of the saturating watchdog counter
//
// Ports:
//   clk, rst_n              pipeline clock, asynchronous active-low reset
//   BranchE, JalrE          taken branch / JALR resolved in EX
//   JalD                    JAL decoded in ID
//   Rs1D, Rs2D              ID-stage source registers
//   Rs1E, Rs2E, RegReadE    EX-stage source registers and their use flags
//   RdE, RdM, RdW           destination register of EX / MEM / WB
//   MemToRegE               EX instruction is a load
//   RegWriteM, RegWriteW    nonzero when MEM / WB instruction writes a reg
//   DCacheMiss, MemReady    MEM-stage miss (level), memory data return (pulse)
//   Stall*, Flush*          per-stage stall and flush controls
//   Forward1E, Forward2E    00 = regfile, 01 = WB, 10 = MEM
//   miss_err                sticky watchdog error
//
// Optional build macro HAZ_PERF_CNT_EN adds the 32-bit performance counters
// stall_cycles and flush_events.
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MISS_TIMEOUT = 255,
    parameter int TO_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BranchE,
    input  logic       JalrE,
    input  logic       JalD,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [1:0] RegReadE,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       MemToRegE,
    input  logic [2:0] RegWriteM,
    input  logic [2:0] RegWriteW,
    input  logic       DCacheMiss,
    input  logic       MemReady,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic       FlushF,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic [1:0] Forward1E,
    output logic [1:0] Forward2E,
    output logic       miss_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic {
        IDLE      = 1'b0,
        MISS_WAIT = 1'b1
    } miss_state_t;

    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MISS_TIMEOUT);

    miss_state_t     state;
    miss_state_t     next_state;
    logic [TO_W-1:0] wd_cnt;
    logic [TO_W-1:0] wd_cnt_next;
    logic            freeze;
    logic            load_use;

    // Forwarding select for one EX operand.  The MEM-stage producer is the
    // youngest, so it wins over WB; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] rs,
        input logic [2:0] wr_m,
        input logic [4:0] rd_m,
        input logic [2:0] wr_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && rs != 5'd0) begin
            if (wr_m != 3'd0 && rd_m == rs) begin
                sel = 2'b10;
            end else if (wr_w != 3'd0 && rd_w == rs) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // The watchdog saturates instead of wrapping so a long-lost memory
    // response can never make the counter roll back under the timeout.
    assign wd_cnt_next = (wd_cnt == {TO_W{1'b1}}) ? wd_cnt : wd_cnt + 1'b1;

    // Miss-wait state register plus watchdog.  The counter restarts on every
    // entry to MISS_WAIT; miss_err is set on the edge that brings the counter
    // to MISS_TIMEOUT so it is visible in the same cycle as that count, and
    // only reset clears it.  The freeze is not released by the error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wd_cnt   <= '0;
            miss_err <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == MISS_WAIT) begin
                wd_cnt <= '0;
            end else if (state == MISS_WAIT) begin
                wd_cnt <= wd_cnt_next;
                if (wd_cnt_next == TIMEOUT_V) begin
                    miss_err <= 1'b1;
                end
            end
        end
    end

    // Next-state logic and all hazard outputs.  The freeze releases
    // combinationally in the MemReady cycle so the MEM register captures the
    // returned data on the following edge.  While frozen, control-flow and
    // load-use requests are ignored; they simply re-evaluate once the miss
    // has been serviced.  During reset every segment is held flushed.
    always_comb begin
        next_state = state;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        StallW     = 1'b0;
        FlushF     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        FlushW     = 1'b0;
        Forward1E  = 2'b00;
        Forward2E  = 2'b00;

        case (state)
            IDLE:      if (DCacheMiss) next_state = MISS_WAIT;
            MISS_WAIT: if (MemReady)   next_state = IDLE;
            default:   next_state = IDLE;
        endcase

        freeze   = (state == IDLE && DCacheMiss) || (state == MISS_WAIT && !MemReady);
        load_use = MemToRegE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

        if (!rst_n) begin
            FlushF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else begin
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (BranchE || JalrE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                // A JAL in ID this cycle is held by the stall, not flushed.
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (JalD) begin
                FlushD = 1'b1;
            end
            Forward1E = fwd_sel(RegReadE[1], Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            Forward2E = fwd_sel(RegReadE[0], Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Performance counters: cycles with any stage stalled, and cycles with a
    // control-flow or load-use flush of ID/EX outside a memory freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (StallF || StallD || StallE || StallM || StallW) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((FlushD || FlushE) && !freeze) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule
